systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences weight/bias loads, skewed data streaming and accumulator drain for an N_PE systolic chain.
// Define SYSCTRL_PERF_EN to build the saturating stream_beats counter; otherwise stream_beats is tied to 0.
module systolic_seq_ctrl #(
  parameter int N_PE = 8,
  parameter int DW = 4,
  parameter int AW = 8,
  localparam int IW = $clog2(N_PE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [DW-1:0]   cmd_data,
  output logic [DW-1:0]   arr_data,
  output logic [DW-1:0]   arr_weight,
  output logic [DW-1:0]   arr_bias,
  output logic [N_PE-1:0] pe_weight_en,
  output logic [N_PE-1:0] pe_bias_en,
  output logic [N_PE-1:0] pe_acc_en,
  output logic [IW-1:0]   drain_sel,
  input  logic [AW-1:0]   arr_acc,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [AW-1:0]   res_data,
  output logic [IW-1:0]   res_idx,
  output logic            busy,
  output logic [7:0]      stream_beats
);
  localparam logic [2:0] OP_LOAD_W = 3'd0;
  localparam logic [2:0] OP_LOAD_B = 3'd1;
  localparam logic [2:0] OP_STREAM = 3'd2;
  localparam logic [2:0] OP_DRAIN  = 3'd3;
  localparam logic [2:0] OP_RST_PTR = 3'd4;
  localparam logic [IW-1:0] LAST = IW'(N_PE - 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_DR_SEL, S_DR_OUT} state_t;

  state_t            r_state, w_next;
  logic [N_PE-1:0]   r_vsr, r_wen, r_ben;
  logic [DW-1:0]     r_data, r_weight, r_bias;
  logic [IW-1:0]     r_wptr, r_bptr, r_idx, r_res_idx;
  logic [AW-1:0]     r_res_data;
  logic              r_res_valid;
  logic              w_cmd_ready, w_busy, w_acc, w_beat, w_ldw, w_ldb, w_rstp, w_drn, w_hs, w_last;

  assign w_acc  = cmd_valid && w_cmd_ready;
  assign w_beat = w_acc && cmd_op == OP_STREAM;
  assign w_ldw  = w_acc && cmd_op == OP_LOAD_W;
  assign w_ldb  = w_acc && cmd_op == OP_LOAD_B;
  assign w_rstp = w_acc && cmd_op == OP_RST_PTR;
  assign w_drn  = w_acc && cmd_op == OP_DRAIN;
  assign w_hs   = r_state == S_DR_OUT && r_res_valid && res_ready;
  assign w_last = r_idx == LAST;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_beat ? S_STREAM : w_drn ? S_DR_SEL : S_IDLE;
      S_STREAM: w_next = (cmd_valid && cmd_op != OP_STREAM) ? S_FLUSH : S_STREAM;
      S_FLUSH:  w_next = (r_vsr == '0) ? S_IDLE : S_FLUSH;
      S_DR_SEL: w_next = S_DR_OUT;
      S_DR_OUT: w_next = w_hs ? (w_last ? S_IDLE : S_DR_SEL) : S_DR_OUT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = r_state == S_IDLE || (r_state == S_STREAM && cmd_op == OP_STREAM);
    w_busy      = r_state != S_IDLE;
  end

  // vsr carries each beat's valid bit down the chain so PE i accumulates i cycles after PE 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vsr    <= '0;
      r_data   <= '0;
      r_wen    <= '0;
      r_ben    <= '0;
      r_weight <= '0;
      r_bias   <= '0;
      r_wptr   <= '0;
      r_bptr   <= '0;
    end else begin
      r_vsr  <= {r_vsr[N_PE-2:0], w_beat};
      r_data <= w_beat ? cmd_data : '0;
      r_wen  <= w_ldw ? N_PE'(1) << r_wptr : '0;
      r_ben  <= w_ldb ? N_PE'(1) << r_bptr : '0;
      if (w_ldw) begin
        r_weight <= cmd_data;
        r_wptr   <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_ldb) begin
        r_bias <= cmd_data;
        r_bptr <= (r_bptr == LAST) ? '0 : r_bptr + 1'b1;
      end
      if (w_rstp) begin
        r_wptr <= '0;
        r_bptr <= '0;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx       <= '0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_drn) r_idx <= '0;
      if (r_state == S_DR_SEL) begin
        r_res_data  <= arr_acc;
        r_res_idx   <= r_idx;
        r_res_valid <= 1'b1;
      end
      if (w_hs) begin
        r_res_valid <= 1'b0;
        r_idx       <= w_last ? '0 : r_idx + 1'b1;
      end
    end

`ifdef SYSCTRL_PERF_EN
  logic [7:0] r_beats;
  always_ff @(posedge clk or posedge rst)
    if (rst)                         r_beats <= '0;
    else if (w_hs && w_last)         r_beats <= '0;
    else if (w_beat && r_beats != 8'hFF) r_beats <= r_beats + 8'd1;
  assign stream_beats = r_beats;
`else
  assign stream_beats = '0;
`endif

  assign cmd_ready    = w_cmd_ready;
  assign busy         = w_busy;
  assign arr_data     = r_data;
  assign arr_weight   = r_weight;
  assign arr_bias     = r_bias;
  assign pe_weight_en = r_wen;
  assign pe_bias_en   = r_ben;
  assign pe_acc_en    = r_vsr;
  assign drain_sel    = r_idx;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_idx      = r_res_idx;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: randomized bench for systolic_seq_ctrl against a cycle-indexed expectation timeline.
module tb_systolic_seq_ctrl;
  localparam logic [2:0] LW = 3'd0, LB = 3'd1, ST = 3'd2, DR = 3'd3, RP = 3'd4;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_data = '0;
  logic [3:0] arr_data, arr_weight, arr_bias;
  logic [7:0] pe_weight_en, pe_bias_en, pe_acc_en;
  logic [2:0] drain_sel, res_idx;
  logic [7:0] arr_acc, res_data, stream_beats;
  logic       res_valid, res_ready = 1'b0, busy;
  logic [7:0] tab [8];

  systolic_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .arr_data(arr_data), .arr_weight(arr_weight), .arr_bias(arr_bias),
    .pe_weight_en(pe_weight_en), .pe_bias_en(pe_bias_en), .pe_acc_en(pe_acc_en),
    .drain_sel(drain_sel), .arr_acc(arr_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .busy(busy), .stream_beats(stream_beats)
  );

  assign arr_acc = tab[drain_sel];
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int wp = 0, bp = 0, tot = 0;
  bit [7:0] e_acc [8192];
  bit [7:0] e_wen [8192];
  bit [7:0] e_ben [8192];
  bit [3:0] e_dat [8192];
  bit [3:0] e_wv  [8192];
  bit [3:0] e_bv  [8192];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask

  function automatic int exp_beats();
`ifdef SYSCTRL_PERF_EN
    return tot > 255 ? 255 : tot;
`else
    return 0;
`endif
  endfunction

  task automatic clear_model();
    for (int i = cyc; i < 8192; i++) begin
      e_acc[i] = '0; e_wen[i] = '0; e_ben[i] = '0; e_dat[i] = '0;
    end
    wp = 0; bp = 0; tot = 0;
  endtask

  // an accept at cycle c shows up at c+1; a beat reaches PE i at c+1+i
  task automatic model_accept(input logic [2:0] op, input logic [3:0] d);
    int c = cyc;
    case (op)
      LW: begin e_wen[c+1] = 8'(1 << wp); e_wv[c+1] = d; wp = (wp + 1) % 8; end
      LB: begin e_ben[c+1] = 8'(1 << bp); e_bv[c+1] = d; bp = (bp + 1) % 8; end
      ST: begin
        e_dat[c+1] = d;
        for (int i = 0; i < 8; i++) e_acc[c+1+i][i] = 1'b1;
        tot++;
      end
      RP: begin wp = 0; bp = 0; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    check("acc_en", pe_acc_en, e_acc[cyc]);
    check("arr_data", arr_data, e_dat[cyc]);
    check("weight_en", pe_weight_en, e_wen[cyc]);
    check("bias_en", pe_bias_en, e_ben[cyc]);
    if (e_wen[cyc] != 0) check("arr_weight", arr_weight, e_wv[cyc]);
    if (e_ben[cyc] != 0) check("arr_bias", arr_bias, e_bv[cyc]);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] d, input bit v);
    tick();
    cmd_valid = v; cmd_op = op; cmd_data = d;
    #1;
    check("rdy_idle", cmd_ready, 1);
    check("busy_idle", busy, 0);
    if (v) model_accept(op, d);
  endtask

  task automatic run_stream(input int nb, input int gap_pct, input bit fixed, output int last);
    int beats = 0;
    logic [3:0] d;
    last = cyc;
    while (beats < nb) begin
      tick();
      check("busy_st", busy, beats > 0);
      if (beats > 0 && $urandom_range(0, 99) < gap_pct) begin
        cmd_valid = 1'b0; cmd_op = 3'($urandom_range(0, 7));
        #1;
        check("rdy_gap", cmd_ready, cmd_op == ST);
      end else begin
        d = fixed ? 4'(2 * beats + 2) : 4'($urandom);
        cmd_valid = 1'b1; cmd_op = ST; cmd_data = d;
        #1;
        check("rdy_st", cmd_ready, 1);
        model_accept(ST, d);
        last = cyc;
        beats++;
      end
    end
  endtask

  task automatic stream_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cmd_valid = 1'b0; cmd_op = 3'($urandom_range(0, 7));
      #1;
      check("rdy_sidle", cmd_ready, cmd_op == ST);
      check("busy_sidle", busy, 1);
    end
  endtask

  // non-stream op offered at d: the flush ends once the last beat has left PE 7
  task automatic flush_then(input logic [2:0] op, input logic [3:0] d, input int last, output int a);
    int f;
    tick();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    f = (cyc + 1 > last + 9) ? cyc + 1 : last + 9;
    while (cyc <= f) begin
      #1;
      check("rdy_flush", cmd_ready, 0);
      check("busy_flush", busy, 1);
      tick();
    end
    #1;
    check("rdy_after", cmd_ready, 1);
    check("busy_after", busy, 0);
    check("beats", stream_beats, exp_beats());
    a = cyc;
    model_accept(op, d);
  endtask

  task automatic do_drain(input int a, input bit rnd, input int bp_idx, input int abort_idx);
    int k = 0, ev = a + 2, hold = 0;
    bit v, rdy;
    for (int g = 0; g < 400; g++) begin
      tick();
      v = (k < 8) && (cyc >= ev);
      if (abort_idx == k && v) begin
        rst = 1'b1;
        #1;
        check("rv_rst", res_valid, 0);
        check("busy_rst", busy, 0);
        check("acc_rst", pe_acc_en, 0);
        check("sel_rst", drain_sel, 0);
        check("ridx_rst", res_idx, 0);
        check("rdat_rst", res_data, 0);
        clear_model();
        res_ready = 1'b0;
        tick();
        rst = 1'b0;
        return;
      end
      check("res_valid", res_valid, v);
      check("busy_dr", busy, k < 8);
      if (k < 8) check("drain_sel", drain_sel, k);
      if (v) begin
        check("res_idx", res_idx, k);
        check("res_data", res_data, tab[k]);
      end
      cmd_valid = 1'b0; cmd_op = 3'($urandom_range(0, 7));
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k == bp_idx && v && hold < 5) begin rdy = 1'b0; hold++; end
      res_ready = rdy;
      #1;
      check("rdy_dr", cmd_ready, k == 8);
      if (k == 8) begin
        check("beats_clr", stream_beats, 0);
        res_ready = 1'b0;
        return;
      end
      if (v && rdy) begin
        k++;
        ev = cyc + 2;
        if (k == 8) tot = 0;
      end
    end
    check("drain_done", k, 8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last, a, t;
    logic [2:0] op;
    logic [3:0] wl [9];
    logic [2:0] ops5 [5];
    wl = '{4'd3, 4'd5, 4'd7, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd9};
    ops5 = '{LW, LB, DR, RP, 3'd6};
    for (int i = 0; i < 8; i++) tab[i] = 8'(8'h10 + i);
    repeat (2) @(negedge clk);
    check("r_busy", busy, 0);
    check("r_res_valid", res_valid, 0);
    check("r_acc_en", pe_acc_en, 0);
    check("r_weight_en", pe_weight_en, 0);
    check("r_bias_en", pe_bias_en, 0);
    check("r_arr_data", arr_data, 0);
    check("r_arr_weight", arr_weight, 0);
    check("r_arr_bias", arr_bias, 0);
    check("r_drain_sel", drain_sel, 0);
    check("r_res_idx", res_idx, 0);
    check("r_res_data", res_data, 0);
    check("r_beats", stream_beats, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_op(LW, wl[i], 1'b1);
    for (int i = 0; i < 30; i++) begin
      t = $urandom_range(0, 5);
      op = t < 2 ? 3'(t) : 3'(t + 2);
      do_op(op, 4'($urandom), $urandom_range(0, 3) != 0);
    end

    run_stream(3, 0, 1'b1, last);
    flush_then(DR, 4'd0, last, a);
    do_drain(a, 1'b0, 3, -1);

    repeat (6) begin
      for (int i = 0; i < 8; i++) tab[i] = 8'($urandom);
      run_stream($urandom_range(1, 20), 30, 1'b0, last);
      stream_idle($urandom_range(0, 12));
      op = ops5[$urandom_range(0, 4)];
      flush_then(op, 4'($urandom), last, a);
      if (op == DR) do_drain(a, 1'b1, $urandom_range(0, 7), -1);
    end

    run_stream(300, 0, 1'b0, last);
    flush_then(DR, 4'd0, last, a);
    do_drain(a, 1'b0, -1, -1);

    repeat (3) do_op(LW, 4'($urandom), 1'b1);
    repeat (5) do_op(LB, 4'($urandom), 1'b1);
    run_stream(5, 0, 1'b0, last);
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("acc_midrst", pe_acc_en, 0);
    check("data_midrst", arr_data, 0);
    check("busy_midrst", busy, 0);
    clear_model();
    tick();
    rst = 1'b0;
    do_op(LW, 4'($urandom), 1'b1);
    do_op(LB, 4'($urandom), 1'b1);

    do_op(LW, 4'($urandom), 1'b1);
    do_op(LB, 4'($urandom), 1'b1);
    run_stream(2, 0, 1'b0, last);
    for (int i = 0; i < 8; i++) tab[i] = 8'(8'h10 + i);
    flush_then(DR, 4'd0, last, a);
    do_drain(a, 1'b1, -1, 4);
    do_op(LW, 4'd5, 1'b1);
    do_op(LB, 4'd6, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
